// File: rtl/i2c_target_regfile.sv
// I2C target with an internal byte-wide register file and a local host port.
// SCL/SDA are synchronised, glitch-filtered and edge-detected on the system clock.
// A pointer selects the register and auto-increments across multi-byte transfers.
module i2c_target_regfile #(
   parameter logic [6:0]  TARGET_ADDR = 7'h50,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYC    = 4,
   localparam int unsigned PW         = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   input  logic          host_we,
   input  logic [PW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic [7:0]    host_rdata,
   output logic          wr_strobe,
   output logic [PW-1:0] wr_index,
   output logic [7:0]    wr_data,
   output logic          busy
);

   localparam int unsigned HoldW    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [8:0]  NumRegsW = 9'(NUM_REGS);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
      StWrData, StWrAck, StRdData, StRdAck, StIgnore
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_s_prev_q, sda_s_prev_q;
   logic                   scl_f_q, sda_f_q, scl_f_prev_q, sda_f_prev_q;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   state_e                 state_q;
   logic [2:0]             bit_cnt_q;
   logic [7:0]             rx_sr_q, tx_sr_q;
   logic [PW-1:0]          ptr_q;
   logic                   rw_q, busy_q, sda_oe_q;
   logic                   hold_act_q;
   logic [HoldW-1:0]       hold_cnt_q;
   logic                   wr_strobe_q;
   logic [PW-1:0]          wr_index_q;
   logic [7:0]             wr_data_q;
   logic [7:0]             host_rdata_q;
   logic [7:0]             regs_q [NUM_REGS];

   logic [7:0]             rx_byte;
   logic                   i2c_we, ptr_ok, drive_val;

   // Synchroniser plus 2-sample agreement filter; idle-high reset avoids fake edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q   <= '1;
         sda_sync_q   <= '1;
         scl_s_prev_q <= 1'b1;
         sda_s_prev_q <= 1'b1;
         scl_f_q      <= 1'b1;
         sda_f_q      <= 1'b1;
         scl_f_prev_q <= 1'b1;
         sda_f_prev_q <= 1'b1;
      end else begin
         scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_s_prev_q <= scl_sync_q[SYNC_STAGES-1];
         sda_s_prev_q <= sda_sync_q[SYNC_STAGES-1];
         if (scl_sync_q[SYNC_STAGES-1] == scl_s_prev_q) scl_f_q <= scl_s_prev_q;
         if (sda_sync_q[SYNC_STAGES-1] == sda_s_prev_q) sda_f_q <= sda_s_prev_q;
         scl_f_prev_q <= scl_f_q;
         sda_f_prev_q <= sda_f_q;
      end
   end

   assign scl_rise  = scl_f_q & ~scl_f_prev_q;
   assign scl_fall  = ~scl_f_q & scl_f_prev_q;
   assign start_det = scl_f_q & scl_f_prev_q & sda_f_prev_q & ~sda_f_q;
   assign stop_det  = scl_f_q & scl_f_prev_q & ~sda_f_prev_q & sda_f_q;

   // Received byte, commit strobe, pointer range check and the level to drive after hold
   always_comb begin
      rx_byte   = {rx_sr_q[6:0], sda_f_q};
      i2c_we    = 1'b0;
      ptr_ok    = ({1'b0, rx_byte} < NumRegsW);
      drive_val = 1'b0;
      if (scl_rise && !start_det && !stop_det && state_q == StWrData && bit_cnt_q == 3'd7) begin
         i2c_we = 1'b1;
      end
      case (state_q)
         StAddrAck, StPtrAck, StWrAck: drive_val = 1'b1;
         StRdData:                     drive_val = ~tx_sr_q[7];
         default:                      drive_val = 1'b0;
      endcase
   end

   // Protocol FSM with registered SDA drive, busy and commit outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         busy_q      <= 1'b0;
         sda_oe_q    <= 1'b0;
         hold_act_q  <= 1'b0;
         hold_cnt_q  <= '0;
         wr_strobe_q <= 1'b0;
         wr_index_q  <= '0;
         wr_data_q   <= '0;
      end else begin
         wr_strobe_q <= i2c_we;
         if (i2c_we) begin
            wr_index_q <= ptr_q;
            wr_data_q  <= rx_byte;
         end
         if (start_det || stop_det) begin
            state_q    <= start_det ? StAddr : StIdle;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            hold_act_q <= 1'b0;
         end else begin
            if (scl_rise) begin
               rx_sr_q <= rx_byte;
               case (state_q)
                  StAddr: begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (rx_byte[7:1] == TARGET_ADDR) begin
                           rw_q    <= rx_byte[0];
                           busy_q  <= 1'b1;
                           state_q <= StAddrAck;
                        end else begin
                           state_q <= StIgnore;
                        end
                     end
                  end
                  StAddrAck: state_q <= rw_q ? StRdData : StPtr;
                  StPtr: begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (ptr_ok) begin
                           ptr_q   <= rx_byte[PW-1:0];
                           state_q <= StPtrAck;
                        end else begin
                           state_q <= StIgnore;
                        end
                     end
                  end
                  StPtrAck, StWrAck: state_q <= StWrData;
                  StWrData: begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        ptr_q   <= ptr_q + 1'b1;
                        state_q <= StWrAck;
                     end
                  end
                  StRdData: begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        ptr_q   <= ptr_q + 1'b1;
                        state_q <= StRdAck;
                     end
                  end
                  // Master NACK ends the read; it may only restart with START
                  StRdAck:  state_q <= sda_f_q ? StIgnore : StRdData;
                  default:  state_q <= state_q;
               endcase
            end
            if (scl_fall) begin
               hold_act_q <= 1'b1;
               hold_cnt_q <= '0;
               if (state_q == StRdData) begin
                  tx_sr_q <= (bit_cnt_q == 3'd0) ? regs_q[ptr_q] : {tx_sr_q[6:0], 1'b0};
               end
            end else if (hold_act_q) begin
               if (hold_cnt_q == HoldW'(HOLD_CYC - 1)) begin
                  hold_act_q <= 1'b0;
                  sda_oe_q   <= drive_val;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
         end
      end
   end

   // Register file; an I2C commit wins over a host write to the same index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         host_rdata_q <= '0;
      end else begin
         if (host_we && !(i2c_we && host_addr == ptr_q)) regs_q[host_addr] <= host_wdata;
         if (i2c_we) regs_q[ptr_q] <= rx_byte;
         host_rdata_q <= regs_q[host_addr];
      end
   end

   assign sda_oe     = sda_oe_q;
   assign busy       = busy_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_index   = wr_index_q;
   assign wr_data    = wr_data_q;
   assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C master plus host port accesses.
module tb_i2c_target_regfile;

   localparam int Q    = 25;  // clk cycles per SCL quarter period
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       host_we = 1'b0;
   logic [3:0] host_addr = '0;
   logic [7:0] host_wdata = '0;
   logic       sda_oe, wr_strobe, busy;
   logic [7:0] host_rdata, wr_data;
   logic [3:0] wr_index;
   logic       sda_line;

   int errors = 0;
   int checks = 0;

   logic [3:0] idx_log [$];
   logic [7:0] dat_log [$];
   int         oe_cnt = 0;
   int         wide_cnt = 0;
   int         hi_viol = 0;
   logic       strobe_prev = 1'b0;
   logic       oe_prev = 1'b0;
   logic       scl_prev = 1'b1;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target_regfile #(
      .TARGET_ADDR(7'h50),
      .NUM_REGS   (16),
      .SYNC_STAGES(SYNC),
      .HOLD_CYC   (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_oe    (sda_oe),
      .host_we   (host_we),
      .host_addr (host_addr),
      .host_wdata(host_wdata),
      .host_rdata(host_rdata),
      .wr_strobe (wr_strobe),
      .wr_index  (wr_index),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   // Bus monitor: commit log, strobe width, SDA activity, SDA changes while SCL high
   always @(negedge clk) begin
      strobe_prev <= wr_strobe;
      oe_prev     <= sda_oe;
      scl_prev    <= scl_m;
      if (wr_strobe) begin
         idx_log.push_back(wr_index);
         dat_log.push_back(wr_data);
      end
      if (wr_strobe && strobe_prev) wide_cnt <= wide_cnt + 1;
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      if (rst_n && scl_m && scl_prev && sda_oe != oe_prev) hi_viol <= hi_viol + 1;
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_q();
      if (!scl_m) begin
         scl_m = 1'b1;
         wait_q();
      end
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b1;
      wait_q();
   endtask

   task automatic send_bit(input logic b, output logic s);
      sda_m = b;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      s = sda_line;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
      send_bit(nack, s);
   endtask

   task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      host_we = 1'b1;
      host_addr = a;
      host_wdata = d;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   task automatic host_rd(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      host_addr = a;
      @(negedge clk);
      d = host_rdata;
   endtask

   // Data byte whose commit edge coincides with a host write of 0x99 to index 4
   task automatic write_byte_collide(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 1; i--) send_bit(b[i], s);
      sda_m = b[0];
      wait_q();
      scl_m = 1'b1;
      repeat (SYNC + 2) @(negedge clk);
      host_we = 1'b1;
      host_addr = 4'd4;
      host_wdata = 8'h99;
      @(negedge clk);
      host_we = 1'b0;
      @(posedge clk);
      #1;
      chk("collide_rdata_next", host_rdata, 8'h77);
      repeat (Q - 7) @(negedge clk);
      wait_q();
      scl_m = 1'b0;
      wait_q();
      send_bit(1'b1, s);
      ack = ~s;
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         n0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_sda_oe", sda_oe, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_strobe", wr_strobe, 1'b0);
      chk("rst_host_rdata", host_rdata, 8'h00);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Multi-byte write from pointer 3
      host_wr(4'd5, 8'hC3);
      n0 = idx_log.size();
      i2c_start();
      write_byte(8'hA0, ack); chk("w1_addr_ack", ack, 1'b1);
      chk("w1_busy", busy, 1'b1);
      write_byte(8'h03, ack); chk("w1_ptr_ack", ack, 1'b1);
      write_byte(8'hA5, ack); chk("w1_d0_ack", ack, 1'b1);
      write_byte(8'h5A, ack); chk("w1_d1_ack", ack, 1'b1);
      i2c_stop();
      chk("w1_busy_after_stop", busy, 1'b0);
      chk("w1_strobe_count", idx_log.size() - n0, 2);
      chk("w1_idx0", idx_log[n0], 4'd3);
      chk("w1_dat0", dat_log[n0], 8'hA5);
      chk("w1_idx1", idx_log[n0+1], 4'd4);
      chk("w1_dat1", dat_log[n0+1], 8'h5A);
      host_rd(4'd3, d); chk("w1_reg3", d, 8'hA5);
      host_rd(4'd4, d); chk("w1_reg4", d, 8'h5A);
      // Pointer left at 5
      i2c_start();
      write_byte(8'hA1, ack); chk("w1_rd_addr_ack", ack, 1'b1);
      read_byte(1'b1, d); chk("w1_ptr5_read", d, 8'hC3);
      i2c_stop();

      // Pointer write, repeated START, wrapping read
      host_wr(4'd15, 8'h11);
      host_wr(4'd0, 8'h22);
      host_wr(4'd1, 8'h33);
      host_wr(4'd2, 8'h44);
      i2c_start();
      write_byte(8'hA0, ack); chk("r2_addr_ack", ack, 1'b1);
      write_byte(8'h0F, ack); chk("r2_ptr_ack", ack, 1'b1);
      i2c_start();
      write_byte(8'hA1, ack); chk("r2_raddr_ack", ack, 1'b1);
      read_byte(1'b0, d); chk("r2_b0", d, 8'h11);
      read_byte(1'b0, d); chk("r2_b1", d, 8'h22);
      read_byte(1'b1, d); chk("r2_b2", d, 8'h33);
      i2c_stop();
      i2c_start();
      write_byte(8'hA1, ack);
      read_byte(1'b1, d); chk("r2_ptr2_read", d, 8'h44);
      i2c_stop();

      // Foreign address is ignored, then a normal write works
      n0 = idx_log.size();
      begin
         int oe0;
         oe0 = oe_cnt;
         i2c_start();
         write_byte(8'hA2, ack); chk("x3_addr_nack", ack, 1'b0);
         chk("x3_busy", busy, 1'b0);
         write_byte(8'h12, ack); chk("x3_data_nack", ack, 1'b0);
         i2c_stop();
         chk("x3_no_drive", oe_cnt - oe0, 0);
         chk("x3_no_strobe", idx_log.size() - n0, 0);
      end
      i2c_start();
      write_byte(8'hA0, ack); chk("x3_good_addr_ack", ack, 1'b1);
      write_byte(8'h07, ack);
      write_byte(8'h9C, ack); chk("x3_good_data_ack", ack, 1'b1);
      i2c_stop();
      host_rd(4'd7, d); chk("x3_reg7", d, 8'h9C);

      // Out-of-range pointer: NACK, data ignored, pointer kept at 8
      host_wr(4'd8, 8'h5E);
      n0 = idx_log.size();
      i2c_start();
      write_byte(8'hA0, ack); chk("p4_addr_ack", ack, 1'b1);
      write_byte(8'h20, ack); chk("p4_ptr_nack", ack, 1'b0);
      write_byte(8'hEE, ack); chk("p4_data_nack", ack, 1'b0);
      i2c_stop();
      chk("p4_no_strobe", idx_log.size() - n0, 0);
      host_rd(4'd0, d); chk("p4_reg0_kept", d, 8'h22);
      i2c_start();
      write_byte(8'hA1, ack);
      read_byte(1'b1, d); chk("p4_ptr_kept", d, 8'h5E);
      i2c_stop();

      // Host write collides with I2C commit on index 4
      n0 = idx_log.size();
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h04, ack);
      write_byte_collide(8'h77, ack); chk("c5_data_ack", ack, 1'b1);
      i2c_stop();
      host_rd(4'd4, d); chk("c5_reg4", d, 8'h77);
      chk("c5_strobe_idx", idx_log[n0], 4'd4);
      chk("c5_strobe_dat", dat_log[n0], 8'h77);

      // Reset while the target drives a 0 data bit
      host_wr(4'd5, 8'h3C);
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h05, ack);
      i2c_start();
      write_byte(8'hA1, ack); chk("r6_addr_ack", ack, 1'b1);
      chk("r6_driving_zero", sda_oe, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("r6_sda_released", sda_oe, 1'b0);
      chk("r6_busy", busy, 1'b0);
      chk("r6_wr_index", wr_index, 4'd0);
      chk("r6_wr_data", wr_data, 8'h00);
      chk("r6_host_rdata", host_rdata, 8'h00);
      scl_m = 1'b1;
      sda_m = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      host_rd(4'd3, d); chk("r6_reg3_cleared", d, 8'h00);
      n0 = idx_log.size();
      i2c_start();
      write_byte(8'hA0, ack); chk("r6_fresh_addr_ack", ack, 1'b1);
      write_byte(8'h01, ack);
      write_byte(8'h66, ack);
      i2c_stop();
      host_rd(4'd1, d); chk("r6_reg1", d, 8'h66);
      chk("r6_strobe_idx", idx_log[n0], 4'd1);

      chk("strobe_width_one", wide_cnt, 0);
      chk("sda_stable_scl_high", hi_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
